// File: rtl/weighted_round_robin_arbiter_if.sv
// Request/weight/accept and grant bundle for the weighted round-robin arbiter.
// The lock signal exists only when WEIGHTED_ROUND_ROBIN_ARBITER_LOCK_EN is defined.
interface weighted_round_robin_arbiter_if #(
  parameter int SIZE         = 4,
  parameter int WEIGHT_WIDTH = 4
);
  localparam int IDX_W = $clog2(SIZE);

  logic [SIZE-1:0]              requests;
  logic [SIZE*WEIGHT_WIDTH-1:0] weights;
  logic                         grant_accept;
`ifdef WEIGHTED_ROUND_ROBIN_ARBITER_LOCK_EN
  logic                         lock;
`endif
  logic [SIZE-1:0]              grant;
  logic [IDX_W-1:0]             grant_index;

  modport master (
    output requests, weights, grant_accept,
`ifdef WEIGHTED_ROUND_ROBIN_ARBITER_LOCK_EN
    output lock,
`endif
    input  grant, grant_index
  );

  modport slave (
    input  requests, weights, grant_accept,
`ifdef WEIGHTED_ROUND_ROBIN_ARBITER_LOCK_EN
    input  lock,
`endif
    output grant, grant_index
  );
endinterface

// File: rtl/weighted_round_robin_arbiter.sv
// Weighted round-robin arbiter (optional packet lock: WEIGHTED_ROUND_ROBIN_ARBITER_LOCK_EN).
// Grant is combinational (0 latency); a grant holds until grant_accept, weight counts accepts.
module weighted_round_robin_arbiter #(
  parameter int SIZE         = 4,
  parameter int WEIGHT_WIDTH = 4
) (
  input logic clock,
  input logic resetn,
  weighted_round_robin_arbiter_if.slave bus
);
  localparam int IDX_W = $clog2(SIZE);

  typedef enum logic {ARBITRATE, HOLD} state_e;

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        ptr_q, ptr_d;
  logic [IDX_W-1:0]        owner_q, owner_d;
  logic [WEIGHT_WIDTH-1:0] credit_q, credit_d;

  logic                    found;
  logic [IDX_W-1:0]        sel;
  logic [IDX_W:0]          cand;
  logic [WEIGHT_WIDTH-1:0] w_field;
  logic [WEIGHT_WIDTH-1:0] eff_w;
  logic                    lock_in;
  logic [SIZE-1:0]         grant_raw;
  logic [IDX_W-1:0]        index_raw;

  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] i);
    if (int'(i) == SIZE - 1) return '0;
    else return i + 1'b1;
  endfunction

`ifdef WEIGHTED_ROUND_ROBIN_ARBITER_LOCK_EN
  assign lock_in = bus.lock;
`else
  assign lock_in = 1'b0;
`endif

  // First asserted request at or after the pointer, wrapping modulo SIZE.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    cand  = '0;
    for (int k = 0; k < SIZE; k++) begin
      cand = {1'b0, ptr_q} + (IDX_W+1)'(k);
      if (cand >= (IDX_W+1)'(SIZE)) cand = cand - (IDX_W+1)'(SIZE);
      if (!found && bus.requests[cand[IDX_W-1:0]]) begin
        found = 1'b1;
        sel   = cand[IDX_W-1:0];
      end
    end
  end

  assign w_field = bus.weights[int'(sel)*WEIGHT_WIDTH +: WEIGHT_WIDTH];
  assign eff_w   = (w_field == '0) ? WEIGHT_WIDTH'(1) : w_field;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    owner_d   = owner_q;
    credit_d  = credit_q;
    grant_raw = '0;
    index_raw = '0;
    case (state_q)
      ARBITRATE: begin
        if (found) begin
          grant_raw[sel] = 1'b1;
          index_raw      = sel;
          if (bus.grant_accept) begin
            if (lock_in) begin
              // A locked accept does not consume credit; the full weight remains.
              state_d  = HOLD;
              owner_d  = sel;
              credit_d = eff_w;
            end else if (eff_w == WEIGHT_WIDTH'(1)) begin
              ptr_d = wrap_inc(sel);
            end else begin
              state_d  = HOLD;
              owner_d  = sel;
              credit_d = eff_w - 1'b1;
            end
          end
        end
      end
      HOLD: begin
        if (bus.requests[owner_q]) begin
          grant_raw[owner_q] = 1'b1;
          index_raw          = owner_q;
          if (bus.grant_accept && !lock_in) begin
            if (credit_q == WEIGHT_WIDTH'(1)) begin
              state_d = ARBITRATE;
              ptr_d   = wrap_inc(owner_q);
            end else begin
              credit_d = credit_q - 1'b1;
            end
          end
        end else begin
          state_d = ARBITRATE;
          ptr_d   = wrap_inc(owner_q);
        end
      end
      default: state_d = ARBITRATE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q  <= ARBITRATE;
      ptr_q    <= '0;
      owner_q  <= '0;
      credit_q <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      owner_q  <= owner_d;
      credit_q <= credit_d;
    end
  end

  assign bus.grant       = resetn ? grant_raw : '0;
  assign bus.grant_index = resetn ? index_raw : '0;

endmodule
